// File: rtl/oled_cmd_pkg.sv
// Shared constants, FSM state type and the power-up command table for the
// OLED command store.
// Optional feature macro: OLED_CMD_DEFAULTS_EN (compiles in the SSD1306 table).
package oled_cmd_pkg;

    localparam int         DEPTH    = 64;
    localparam logic [6:0] SEQ_LAST = 7'd40;   // index of the last transmitted byte
    localparam logic [7:0] NOP_BYTE = 8'hE3;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_DONE,
        ST_RST_PULSE
    } state_t;

`ifdef OLED_CMD_DEFAULTS_EN
    // SSD1306 power-up sequence; entries past index 24 are padding NOPs.
    localparam logic [7:0] INIT_TABLE [0:DEPTH-1] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
        8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
        8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
        8'hAF, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3,
        8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3,
        8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3,
        8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3,
        8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3, 8'hE3
    };
`endif

endpackage

// File: rtl/oled_cmd_store.sv
// Host-loadable 64x8 command store feeding the I2C OLED controller.
// After reset it fills the RAM (64 cycles), then releases ctrl; serves
// cmd_data one cycle after cmd_address, flags end of pass, and restarts ctrl
// with a 2-cycle reset pulse on refresh.
// Optional feature macro: OLED_CMD_DEFAULTS_EN (INIT loads the SSD1306 table;
// otherwise every entry is initialised to NOP_BYTE).
//
// Ports:
//   clk2        clock shared with ctrl
//   reset       asynchronous, active-low
//   wr_en/wr_addr/wr_data  host write request (held until wr_ack)
//   wr_ack      combinational acknowledge; write commits on that edge
//   refresh     retransmit request, only honoured once a pass has finished
//   cmd_address byte index from ctrl; bit 6 selects the NOP byte
//   cmd_data    registered read data
//   ctrl_rst_n  active-low reset to ctrl
//   ready       initialisation complete
//   busy        transmit pass in progress
//   tx_done     one-cycle end-of-pass pulse
module oled_cmd_store
    import oled_cmd_pkg::*;
(
    input  logic       clk2,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    input  logic       refresh,
    input  logic [6:0] cmd_address,
    output logic [7:0] cmd_data,
    output logic       ctrl_rst_n,
    output logic       ready,
    output logic       busy,
    output logic       tx_done
);

    // RAM is deliberately not reset; INIT rewrites every entry.
    logic [7:0] r_mem [0:DEPTH-1];

    state_t     r_state;
    logic [5:0] r_idx;
    logic       r_pulse_cnt;
    logic [6:0] r_prev_addr;
    logic [7:0] r_cmd_data;
    logic       r_ctrl_rst_n;
    logic       r_ready;
    logic       r_busy;
    logic       r_tx_done;

    logic       w_wr_ack;
    logic       w_mem_we;
    logic [5:0] w_mem_addr;
    logic [7:0] w_mem_wdat;
    logic [7:0] w_init_byte;

`ifdef OLED_CMD_DEFAULTS_EN
    assign w_init_byte = INIT_TABLE[r_idx];
`else
    assign w_init_byte = NOP_BYTE;
`endif

    // Host writes stall during INIT because the init sweep owns the write port.
    assign w_wr_ack   = wr_en & (r_state != ST_INIT);
    assign w_mem_we   = (r_state == ST_INIT) | w_wr_ack;
    assign w_mem_addr = (r_state == ST_INIT) ? r_idx : wr_addr;
    assign w_mem_wdat = (r_state == ST_INIT) ? w_init_byte : wr_data;

    always_ff @(posedge clk2) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdat;
        end
    end

    // Read-before-write: a same-edge write to the read address returns old data.
    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            r_cmd_data <= 8'h00;
        end else if (cmd_address[6]) begin
            r_cmd_data <= NOP_BYTE;
        end else begin
            r_cmd_data <= r_mem[cmd_address[5:0]];
        end
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_INIT;
            r_idx        <= 6'd0;
            r_pulse_cnt  <= 1'b0;
            r_prev_addr  <= 7'd0;
            r_ctrl_rst_n <= 1'b0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_tx_done    <= 1'b0;
        end else begin
            r_prev_addr <= cmd_address;
            r_tx_done   <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_idx <= r_idx + 6'd1;
                    if (r_idx == 6'(DEPTH - 1)) begin
                        r_state      <= ST_RUN;
                        r_ctrl_rst_n <= 1'b1;
                        r_ready      <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // ctrl wraps its index from the last byte back to 0 at end of pass.
                    if (r_prev_addr == SEQ_LAST && cmd_address == 7'd0) begin
                        r_tx_done <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (refresh) begin
                        r_state      <= ST_RST_PULSE;
                        r_ctrl_rst_n <= 1'b0;
                        r_pulse_cnt  <= 1'b0;
                    end
                end
                ST_RST_PULSE: begin
                    // Second cycle of the pulse: release ctrl on this edge.
                    if (r_pulse_cnt) begin
                        r_state      <= ST_RUN;
                        r_ctrl_rst_n <= 1'b1;
                        r_busy       <= 1'b1;
                    end else begin
                        r_pulse_cnt <= 1'b1;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign wr_ack     = w_wr_ack;
    assign cmd_data   = r_cmd_data;
    assign ctrl_rst_n = r_ctrl_rst_n;
    assign ready      = r_ready;
    assign busy       = r_busy;
    assign tx_done    = r_tx_done;

endmodule

// File: tb/tb_oled_cmd_store.sv
// Bench for oled_cmd_store: behavioural model + per-cycle compare, a ctrl
// model stepping cmd_address, randomized host traffic and literal checks.
module tb_oled_cmd_store;

    logic       clk2 = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [5:0] wr_addr = 6'd0;
    logic [7:0] wr_data = 8'd0;
    logic       wr_ack;
    logic       refresh = 1'b0;
    logic [6:0] cmd_address = 7'd0;
    logic [7:0] cmd_data;
    logic       ctrl_rst_n;
    logic       ready;
    logic       busy;
    logic       tx_done;

    oled_cmd_store dut (
        .clk2        (clk2),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ack      (wr_ack),
        .refresh     (refresh),
        .cmd_address (cmd_address),
        .cmd_data    (cmd_data),
        .ctrl_rst_n  (ctrl_rst_n),
        .ready       (ready),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    always #5 clk2 = ~clk2;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] tb_init_byte(input int i);
`ifdef OLED_CMD_DEFAULTS_EN
        case (i)
            0: return 8'hAE;  1: return 8'hD5;  2: return 8'h80;  3: return 8'hA8;
            4: return 8'h3F;  5: return 8'hD3;  6: return 8'h00;  7: return 8'h40;
            8: return 8'h8D;  9: return 8'h14; 10: return 8'h20; 11: return 8'h00;
            12: return 8'hA1; 13: return 8'hC8; 14: return 8'hDA; 15: return 8'h12;
            16: return 8'h81; 17: return 8'hCF; 18: return 8'hD9; 19: return 8'hF1;
            20: return 8'hDB; 21: return 8'h40; 22: return 8'hA4; 23: return 8'hA6;
            24: return 8'hAF;
            default: return 8'hE3;
        endcase
`else
        if (i < 0) return 8'h00;
        return 8'hE3;
`endif
    endfunction

    // ---------------- behavioural model ----------------
    // phase: 0 init sweep, 1 transmitting, 2 finished, 3 ctrl reset pulse
    int         m_phase = 0;
    int         m_init_cnt = 0;
    int         m_pulse_cnt = 0;
    logic [6:0] m_prev = 7'd0;
    logic [7:0] e_cmd = 8'h00;
    bit         e_cmd_ok = 1'b1;
    bit         e_tx = 1'b0;
    logic [7:0] m_mem [64];
    bit         m_known [64];
    logic [7:0] m_rd;
    bit         m_rd_ok;

    always @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_init_cnt = 0; m_pulse_cnt = 0; m_prev = 7'd0;
            e_cmd = 8'h00; e_cmd_ok = 1'b1; e_tx = 1'b0;
        end else begin
            if (cmd_address >= 7'd64) begin
                m_rd = 8'hE3; m_rd_ok = 1'b1;
            end else begin
                m_rd = m_mem[cmd_address]; m_rd_ok = m_known[cmd_address];
            end
            e_tx = 1'b0;
            if (m_phase == 0) begin
                m_mem[m_init_cnt] = tb_init_byte(m_init_cnt);
                m_known[m_init_cnt] = 1'b1;
                if (m_init_cnt == 63) m_phase = 1;
                else m_init_cnt++;
            end else begin
                if (wr_en) begin
                    m_mem[wr_addr] = wr_data;
                    m_known[wr_addr] = 1'b1;
                end
                if (m_phase == 1 && m_prev == 7'd40 && cmd_address == 7'd0) begin
                    e_tx = 1'b1; m_phase = 2;
                end else if (m_phase == 2 && refresh) begin
                    m_phase = 3; m_pulse_cnt = 2;
                end else if (m_phase == 3) begin
                    m_pulse_cnt--;
                    if (m_pulse_cnt == 0) m_phase = 1;
                end
            end
            m_prev = cmd_address;
            e_cmd = m_rd; e_cmd_ok = m_rd_ok;
        end
    end

    bit cmp_en = 1'b0;
    always @(negedge clk2) begin
        if (cmp_en) begin
            if (e_cmd_ok) check("cmd_data", {24'd0, cmd_data}, {24'd0, e_cmd});
            check("ctrl_rst_n", {31'd0, ctrl_rst_n}, {31'd0, (m_phase == 1 || m_phase == 2)});
            check("ready", {31'd0, ready}, {31'd0, (m_phase != 0)});
            check("busy", {31'd0, busy}, {31'd0, (m_phase == 1)});
            check("tx_done", {31'd0, tx_done}, {31'd0, e_tx});
            check("wr_ack", {31'd0, wr_ack}, {31'd0, (wr_en && m_phase != 0)});
        end
    end

    // ---------------- ctrl model ----------------
    int         c_pos = 0;
    int         c_hold = 0;
    bit         c_run = 1'b0;
    bit         free_mode = 1'b0;
    logic [6:0] free_addr = 7'd0;
    logic [7:0] rx [$];

    initial begin
        forever begin
            @(negedge clk2); #1;
            if (!ctrl_rst_n) begin
                c_pos = 0; c_hold = 0; c_run = 1'b1; cmd_address = 7'd0;
            end else if (c_run) begin
                c_hold++;
                if (c_hold == 9) begin
                    rx.push_back(cmd_data);
                    c_hold = 0;
                    if (c_pos == 40) begin
                        c_run = 1'b0; cmd_address = 7'd0;
                    end else begin
                        c_pos++; cmd_address = 7'(c_pos);
                    end
                end
            end else if (free_mode) begin
                cmd_address = free_addr;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] sh [64];   // expected RAM contents as seen by the host
    int         td_cnt = 0;

    task automatic step();
        @(negedge clk2); #1;
        if (tx_done === 1'b1) td_cnt++;
    endtask

    task automatic load_sh_from_table();
        for (int i = 0; i < 64; i++) sh[i] = tb_init_byte(i);
    endtask

    task automatic wait_init(input bit wr_at_10);
        int n;
        n = 0;
        while (!ctrl_rst_n && n < 200) begin
            step(); n++;
            if (wr_at_10 && n == 10) begin
                wr_en = 1'b1; wr_addr = 6'd50; wr_data = 8'h5A;
            end
            if (!ctrl_rst_n) check("wr_ack_in_init", {31'd0, wr_ack}, 32'd0);
        end
        check("init_cycles", n, 64);
    endtask

    task automatic wait_pass();
        int n;
        int a;
        logic [7:0] d;
        n = 0; td_cnt = 0;
        while (busy && n < 3000) begin
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom_range(51, 63); d = 8'($urandom);
                wr_en = 1'b1; wr_addr = 6'(a); wr_data = d;
                step();
                wr_en = 1'b0; sh[a] = d;
            end else begin
                step();
            end
            n++;
        end
        check("pass_timeout", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 20; i++) step();
        check("tx_done_count", td_cnt, 1);
        check("rx_len", rx.size(), 41);
        for (int i = 0; i < 41; i++)
            if (i < rx.size()) check($sformatf("rx_byte_%0d", i), {24'd0, rx[i]}, {24'd0, sh[i]});
    endtask

    task automatic do_refresh(output int low);
        free_addr = 7'd0; step(); free_mode = 1'b0;
        rx.delete();
        refresh = 1'b1; step(); refresh = 1'b0;
        low = 0;
        for (int i = 0; i < 10; i++) begin
            if (!ctrl_rst_n) low++;
            else if (low > 0) break;
            step();
        end
    endtask

    task automatic free_read(input logic [6:0] a, output logic [7:0] v);
        free_addr = a; step(); step(); v = cmd_data;
    endtask

    initial begin
        int low;
        int acks;
        int a;
        logic [7:0] v;
        logic [7:0] d;
        logic [7:0] old;

        // reset and init, with a host write held from cycle 10
        step(); step();
        cmp_en = 1'b1;
        check("rst_cmd_data", {24'd0, cmd_data}, 32'd0);
        check("rst_ctrl_rst_n", {31'd0, ctrl_rst_n}, 32'd0);
        rx.delete();
        reset = 1'b1;
        load_sh_from_table();
        wait_init(1'b1);
        check("init_wr_ack_run", {31'd0, wr_ack}, 32'd1);
        step(); wr_en = 1'b0; sh[50] = 8'h5A;

        // first pass
        wait_pass();
`ifdef OLED_CMD_DEFAULTS_EN
        if (rx.size() == 41) begin
            check("lit_rx0", {24'd0, rx[0]}, 32'hAE);
            check("lit_rx24", {24'd0, rx[24]}, 32'hAF);
            check("lit_rx40", {24'd0, rx[40]}, 32'hE3);
        end
`else
        if (rx.size() == 41) begin
            check("lit_rx0", {24'd0, rx[0]}, 32'hE3);
            check("lit_rx24", {24'd0, rx[24]}, 32'hE3);
        end
`endif

        // finished state: free reads, collision, out-of-range
        free_mode = 1'b1;
        free_read(7'd50, v);
        check("lit_init_write_kept", {24'd0, v}, 32'h5A);
        for (int i = 0; i < 20; i++) begin
            free_addr = 7'($urandom_range(0, 127)); step();
        end
        free_read(7'd5, v);
        old = sh[5]; d = ~old;
        check("coll_before", {24'd0, v}, {24'd0, old});
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = d;
        step();
        wr_en = 1'b0; sh[5] = d;
        check("coll_old", {24'd0, cmd_data}, {24'd0, old});
        step();
        check("coll_new", {24'd0, cmd_data}, {24'd0, d});
        free_read(7'd64, v);
        check("lit_oor_64", {24'd0, v}, 32'hE3);
        free_read(7'd100, v);
        check("lit_oor_100", {24'd0, v}, 32'hE3);

        // random back-to-back burst
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = $urandom_range(0, 40); d = 8'($urandom);
            wr_addr = 6'(a); wr_data = d;
            step(); sh[a] = d;
        end
        wr_en = 1'b0;

        // edit byte 16 and count acknowledge cycles
        acks = 0;
        wr_en = 1'b1; wr_addr = 6'd16; wr_data = 8'h7F;
        #1; if (wr_ack) acks++;
        step(); wr_en = 1'b0; sh[16] = 8'h7F;
        for (int i = 0; i < 3; i++) begin
            #1; if (wr_ack) acks++;
            step();
        end
        check("edit_ack_cycles", acks, 1);

        do_refresh(low);
        check("refresh_low_cycles", low, 2);
        wait_pass();
        if (rx.size() == 41) check("lit_rx16_edit", {24'd0, rx[16]}, 32'h7F);

        // third pass interrupted by reset at byte 20
        do_refresh(low);
        check("refresh2_low_cycles", low, 2);
        for (int i = 0; i < 1000 && c_pos < 20; i++) step();
        check("reach_byte20", c_pos, 20);
        reset = 1'b0;
        #1;
        check("mid_rst_cmd_data", {24'd0, cmd_data}, 32'd0);
        check("mid_rst_ctrl_rst_n", {31'd0, ctrl_rst_n}, 32'd0);
        check("mid_rst_ready", {31'd0, ready}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_tx_done", {31'd0, tx_done}, 32'd0);
        check("mid_rst_wr_ack", {31'd0, wr_ack}, 32'd0);
        step(); step(); step();
        rx.delete();
        reset = 1'b1;
        load_sh_from_table();
        wait_init(1'b0);
        wait_pass();
        if (rx.size() == 41) check("lit_rx16_restored", {24'd0, rx[16]}, {24'd0, tb_init_byte(16)});
`ifdef OLED_CMD_DEFAULTS_EN
        if (rx.size() == 41) check("lit_rx16_table", {24'd0, rx[16]}, 32'h81);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
